// File: rtl/cpu_alu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_alu_pkg
// Shared definitions for the CPU ALU datapath blocks.
//   alu_op_e       : add/subtract operation select (ALU_ADD / ALU_SUB)
//   DEFAULT_WIDTH  : default operand width of the pipelined adder/subtractor
//   DEFAULT_CHUNK  : default slice width resolved per pipeline stage
//   first_carry()  : carry injected into the least-significant slice
// -----------------------------------------------------------------------------
package cpu_alu_pkg;

    typedef enum logic [0:0] {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // Subtraction completes the two's-complement negation of B with a forced +1,
    // so the external carry-in only matters in add mode.
    function automatic logic first_carry(input logic sub, input logic cin);
        logic carry_s;
        if (sub == ALU_SUB) begin
            carry_s = 1'b1;
        end else begin
            carry_s = cin;
        end
        return carry_s;
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub_if
// Operand/result handshake bundle for cla_pipe_addsub.
//   in_valid/in_ready   : operand beat handshake (producer -> adder)
//   in_a, in_b          : operands, WIDTH bits
//   in_sub              : 0 = A+B+cin, 1 = A-B
//   in_cin              : carry-in, add mode only
//   out_valid/out_ready : result beat handshake (adder -> consumer)
//   out_sum             : result, WIDTH bits
//   out_cout            : carry out of MSB (sub: 1 = no borrow)
//   out_ovf             : signed overflow
//   out_zero            : result is zero
// Modports: master = operand producer / result consumer, slave = the adder.
// -----------------------------------------------------------------------------
interface cla_pipe_addsub_if
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/cla_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
// Combinational CHUNK-bit carry-lookahead adder slice.
//   a, b      : slice operands (b already conditioned for subtraction)
//   cin       : carry into bit 0
//   s         : slice sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (used for signed overflow)
// Every internal carry is a flat sum-of-products of generate/propagate terms
// and cin, so no carry depends on another carry.
// -----------------------------------------------------------------------------
module cla_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] g_s;
    logic [CHUNK-1:0] p_s;
    logic [CHUNK:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        logic pp_s;
        c_s    = {(CHUNK + 1){1'b0}};
        pp_s   = 1'b0;
        c_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            c_s[i+1] = g_s[i];
            pp_s     = p_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                c_s[i+1] = c_s[i+1] | (pp_s & g_s[j]);
                pp_s     = pp_s & p_s[j];
            end
            c_s[i+1] = c_s[i+1] | (pp_s & cin);
        end
    end

    assign s        = p_s ^ c_s[CHUNK-1:0];
    assign cout     = c_s[CHUNK];
    assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor. Operands are cut into
// N = WIDTH/CHUNK slices; stage k resolves slice k using the carry registered
// by stage k-1, so one result per cycle leaves after N register stages.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, discards all in-flight beats
//   bus      : cla_pipe_addsub_if.slave (operand in, result out, valid/ready)
// The whole pipe shifts as one unit whenever the output slot is empty or being
// drained; bubbles travel like valid beats. The last stage register drives the
// outputs directly, so a stalled result is held stable.
// -----------------------------------------------------------------------------
module cla_pipe_addsub
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_pipe_addsub_if.slave      bus
);

    localparam int N = WIDTH / CHUNK;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("cla_pipe_addsub: WIDTH must be a positive integer multiple of CHUNK");
    end

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             carry0_s;
    logic             ovf_r;
    logic             zero_r;

    // Operand conditioning: subtraction feeds ~B with a forced carry of 1
    always_comb begin
        b_eff_s  = {WIDTH{1'b0}};
        carry0_s = first_carry(bus.in_sub, bus.in_cin);
        if (bus.in_sub == ALU_SUB) begin
            b_eff_s = ~bus.in_b;
        end else begin
            b_eff_s = bus.in_b;
        end
    end

    // Shift when nothing is waiting at the output or it is being taken now;
    // depends only on out_valid/out_ready, never on in_valid.
    assign adv_s        = !g_stage[N-1].valid_r || bus.out_ready;
    assign bus.in_ready = adv_s;

    for (genvar k = 0; k < N; k++) begin : g_stage
        // Operand word arriving at this stage: slices below k already hold sum
        // bits, slices k and above still hold A. B' only carries what is left.
        logic                      src_valid_s;
        logic                      src_carry_s;
        logic [WIDTH-1:0]          src_mix_s;
        logic [WIDTH-1:k*CHUNK]    src_b_s;
        logic [CHUNK-1:0]          slice_sum_s;
        logic                      slice_cout_s;
        logic                      slice_cmsb_s;
        logic [WIDTH-1:0]          next_mix_s;
        logic                      valid_r;
        logic                      carry_r;
        logic [WIDTH-1:0]          mix_r;

        if (k == 0) begin : g_src_in
            assign src_valid_s = bus.in_valid;
            assign src_carry_s = carry0_s;
            assign src_mix_s   = bus.in_a;
            assign src_b_s     = b_eff_s;
        end else begin : g_src_prev
            assign src_valid_s = g_stage[k-1].valid_r;
            assign src_carry_s = g_stage[k-1].carry_r;
            assign src_mix_s   = g_stage[k-1].mix_r;
            assign src_b_s     = g_stage[k-1].g_fwd.b_r;
        end

        cla_slice #(
            .CHUNK    (CHUNK)
        ) u_slice (
            .a        (src_mix_s[k*CHUNK +: CHUNK]),
            .b        (src_b_s[k*CHUNK +: CHUNK]),
            .cin      (src_carry_s),
            .s        (slice_sum_s),
            .cout     (slice_cout_s),
            .c_msb_in (slice_cmsb_s)
        );

        // Replace slice k of the travelling word with its resolved sum bits
        always_comb begin
            next_mix_s                   = src_mix_s;
            next_mix_s[k*CHUNK +: CHUNK] = slice_sum_s;
        end

        // Stage register: valid, carry into next slice, partially resolved word
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_r <= 1'b0;
                carry_r <= 1'b0;
                mix_r   <= {WIDTH{1'b0}};
            end else if (adv_s) begin
                valid_r <= src_valid_s;
                carry_r <= slice_cout_s;
                mix_r   <= next_mix_s;
            end
        end

        if (k < N - 1) begin : g_fwd
            logic                        cmsb_unused_s;
            logic [WIDTH-1:(k+1)*CHUNK]  b_r;

            // Only the final slice's MSB carry matters for overflow
            assign cmsb_unused_s = slice_cmsb_s;

            // Forward the B' slices that later stages have not consumed yet
            always_ff @(posedge clk) begin
                if (rst) begin
                    b_r <= {(WIDTH - (k + 1) * CHUNK){1'b0}};
                end else if (adv_s) begin
                    b_r <= src_b_s[WIDTH-1:(k+1)*CHUNK];
                end
            end
        end else begin : g_flags
            // Result flags; carry-in to MSB differing from carry-out is exactly
            // the case of equal-sign operands producing an opposite-sign sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (adv_s) begin
                    ovf_r  <= slice_cmsb_s ^ slice_cout_s;
                    zero_r <= (next_mix_s == {WIDTH{1'b0}});
                end
            end
        end
    end

    assign bus.out_valid = g_stage[N-1].valid_r;
    assign bus.out_sum   = g_stage[N-1].mix_r;
    assign bus.out_cout  = g_stage[N-1].carry_r;
    assign bus.out_ovf   = ovf_r;
    assign bus.out_zero  = zero_r;

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the CPU datapath, the successor to the fixed 4-bit combinational CLA. Operands are split into CHUNK-bit slices; one slice is resolved per pipeline stage with a registered carry between stages, giving one result per cycle at any WIDTH with a short critical path. A valid/ready handshake on both sides supports stalls from downstream consumers such as the ALU writeback mux.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK (elaboration error otherwise)
- CHUNK, 4, slice width resolved per stage; N = WIDTH/CHUNK stages
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sub  input  1  0 = A+B+cin, 1 = A+~B+1 (cin ignored)
- in_cin  input  1  carry-in for add mode
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB (sub: 1 = no borrow)
- out_ovf  output  1  signed two's-complement overflow
- out_zero  output  1  out_sum == 0

## Operation
- Accept when in_valid && in_ready. Sub mode: B' = ~in_b, carry0 = 1; add mode: B' = in_b, carry0 = in_cin.
- Stage k (0..N-1) computes slice k: sum[k*CHUNK +: CHUNK] and carry via cla_slice from A/B' slice k and the carry registered by stage k-1 (carry0 for k=0).
- Each stage register holds: valid, carry, resolved result slices 0..k, unconsumed A/B' slices k+1..N-1.
- Final stage register drives outputs directly; out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]); out_zero computed from the complete sum in the last stage.
- Advance condition adv = !out_valid || out_ready; whole pipe shifts together when adv, holds otherwise. in_ready = adv.
- Bubbles: invalid stages shift like valid ones; no compaction.
- Results leave in acceptance order; none dropped or duplicated.
- While out_valid && !out_ready all outputs are held stable.

## Timing
- Reset: all stage valid bits 0; out_valid 0, out_sum 0, out_cout 0, out_ovf 0, out_zero 0; in_ready 1 in first cycle after reset deasserts.
- rst mid-operation: all in-flight beats discarded; out_valid 0 on the cycle after rst sampled high; beat presented on a rst cycle not accepted.
- Latency: beat accepted at edge t appears with out_valid = 1 after edge t+N-1 (N cycles of registers counting the output stage), i.e. N=4 at defaults.
- Throughput: 1 beat/cycle when out_ready held high.
- Simultaneous accept and output handoff in the same cycle is legal and required (full pipe, out_ready=1, in_valid=1 -> both transfer).
- in_ready is combinational from out_ready and out_valid only; no path from in_valid.
- N=1 (WIDTH == CHUNK) degenerates to a single registered CLA with same handshake.

## Structure
- Shared package cpu_alu_pkg: op-mode constants (ALU_ADD=0, ALU_SUB=1), default WIDTH/CHUNK localparams.
- Sub-module cla_slice #(CHUNK): combinational generate/propagate lookahead over CHUNK bits, ports a, b, cin, s, cout, plus c_msb_in (carry into MSB) for overflow; instantiated N times via generate.
- Top holds stage registers, skew of operand slices, handshake and flag logic.

## Test plan
- Add 0x7FFF + 0x0001, cin 0, out_ready 1 -> after 4 cycles out_sum 0x8000, cout 0, ovf 1, zero 0.
- Sub 0x0005 - 0x0005 -> out_sum 0x0000, cout 1, ovf 0, zero 1; sub 0x0000 - 0x0001 -> 0xFFFF, cout 0, ovf 0.
- Full carry chain: 0xFFFF + 0x0000, cin 1 -> out_sum 0x0000, cout 1, zero 1, exercising carry through all 4 stages.
- Back-to-back 8 beats, out_ready low for 3 cycles mid-stream -> in_ready low exactly those cycles, outputs held stable, all 8 results correct and in order.
- 3 beats in flight, rst pulsed 1 cycle -> out_valid 0 next cycle, none of the 3 emerge, next accepted beat returns after 4 cycles.
- WIDTH=32 CHUNK=8 and WIDTH=8 CHUNK=8: 10k random add/sub beats with random out_ready vs. reference model -> zero mismatches, latency 4 and 1 respectively.
